// File: rtl/fpadd_scheduler.sv
// ---------------------------------------------------------------------------
// fpadd_scheduler
//
// Round-robin issue scheduler sharing one fixed-latency pipelined FP
// add/subtract datapath between two requesters. Operand sets are accepted
// over valid/ready handshakes. At most one is issued per cycle into the
// registered pipe_* outputs. A {valid, id} tag delay line follows each
// operation through the external pipeline, so the result is routed back to
// the requester that issued it.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   req{0,1}_valid / _ready        operand handshake (ready is combinational)
//   req{0,1}_a/_b (23) _p/_q (8)   mantissa / exponent operands
//   req{0,1}_m                     mode, 1 = add, 0 = subtract
//   pipe_a/_b/_p/_q/_m, pipe_valid registered operands to the shared datapath
//   pipe_exp, pipe_mant            datapath result, valid LATENCY edges after
//                                  the operands change
//   rsp{0,1}_valid                 one-cycle result pulse per requester
//   rsp{0,1}_exp / _mant           result, held until that port's next pulse
//   busy                           high while any operation is in flight
// ---------------------------------------------------------------------------
module fpadd_scheduler #(
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [22:0] req0_a,
    input  logic [22:0] req0_b,
    input  logic [7:0]  req0_p,
    input  logic [7:0]  req0_q,
    input  logic        req0_m,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [22:0] req1_a,
    input  logic [22:0] req1_b,
    input  logic [7:0]  req1_p,
    input  logic [7:0]  req1_q,
    input  logic        req1_m,

    output logic [22:0] pipe_a,
    output logic [22:0] pipe_b,
    output logic [7:0]  pipe_p,
    output logic [7:0]  pipe_q,
    output logic        pipe_m,
    output logic        pipe_valid,
    input  logic [7:0]  pipe_exp,
    input  logic [22:0] pipe_mant,

    output logic        rsp0_valid,
    output logic [7:0]  rsp0_exp,
    output logic [22:0] rsp0_mant,
    output logic        rsp1_valid,
    output logic [7:0]  rsp1_exp,
    output logic [22:0] rsp1_mant,

    output logic        busy
);

    // Outstanding count spans 0..LATENCY+1.
    localparam int CW = $clog2(LATENCY + 2);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    // Arbitration
    logic grant0;
    logic grant1;
    logic issue;
    logic win_id;

    // Registered state
    logic [22:0]    pipe_a_q, pipe_a_d;
    logic [22:0]    pipe_b_q, pipe_b_d;
    logic [7:0]     pipe_p_q, pipe_p_d;
    logic [7:0]     pipe_q_q, pipe_q_d;
    logic           pipe_m_q, pipe_m_d;
    logic           pipe_valid_q, pipe_valid_d;
    logic           last_q, last_d;
    logic [LATENCY:0] tag_vld_q, tag_vld_d;
    logic [LATENCY:0] tag_id_q, tag_id_d;
    logic [CW-1:0]  count_q, count_d;
    logic           rsp0_valid_q, rsp0_valid_d;
    logic [7:0]     rsp0_exp_q, rsp0_exp_d;
    logic [22:0]    rsp0_mant_q, rsp0_mant_d;
    logic           rsp1_valid_q, rsp1_valid_d;
    logic [7:0]     rsp1_exp_q, rsp1_exp_d;
    logic [22:0]    rsp1_mant_q, rsp1_mant_d;

    logic rsp_fire;
    logic rsp_id;

    // last_q = 1 means req1 was granted most recently, so req0 wins a tie.
    // Grants are suppressed during reset so nothing is accepted on a reset edge.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst) begin
            if (req0_valid && (!req1_valid || last_q)) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign issue      = grant0 | grant1;
    assign win_id     = grant1;

    // Tag delay line: stage 0 captures this cycle's issue, every stage shifts
    // unconditionally. Stage LATENCY lines up with the datapath result.
    assign tag_vld_d[0] = issue;
    assign tag_id_d[0]  = win_id;

    genvar gi;
    generate
        for (gi = 1; gi <= LATENCY; gi++) begin : g_tag
            assign tag_vld_d[gi] = tag_vld_q[gi-1];
            assign tag_id_d[gi]  = tag_id_q[gi-1];
        end
    endgenerate

    assign rsp_fire = tag_vld_q[LATENCY];
    assign rsp_id   = tag_id_q[LATENCY];

    // Issue path: operands held when nothing is issued.
    always_comb begin
        pipe_a_d     = pipe_a_q;
        pipe_b_d     = pipe_b_q;
        pipe_p_d     = pipe_p_q;
        pipe_q_d     = pipe_q_q;
        pipe_m_d     = pipe_m_q;
        pipe_valid_d = issue;
        last_d       = last_q;
        if (grant0) begin
            pipe_a_d = req0_a;
            pipe_b_d = req0_b;
            pipe_p_d = req0_p;
            pipe_q_d = req0_q;
            pipe_m_d = req0_m;
            last_d   = 1'b0;
        end else if (grant1) begin
            pipe_a_d = req1_a;
            pipe_b_d = req1_b;
            pipe_p_d = req1_p;
            pipe_q_d = req1_q;
            pipe_m_d = req1_m;
            last_d   = 1'b1;
        end
    end

    // Response path: only the addressed port's data registers are updated.
    always_comb begin
        rsp0_valid_d = rsp_fire & ~rsp_id;
        rsp1_valid_d = rsp_fire & rsp_id;
        rsp0_exp_d   = rsp0_exp_q;
        rsp0_mant_d  = rsp0_mant_q;
        rsp1_exp_d   = rsp1_exp_q;
        rsp1_mant_d  = rsp1_mant_q;
        if (rsp_fire && !rsp_id) begin
            rsp0_exp_d  = pipe_exp;
            rsp0_mant_d = pipe_mant;
        end
        if (rsp_fire && rsp_id) begin
            rsp1_exp_d  = pipe_exp;
            rsp1_mant_d = pipe_mant;
        end
    end

    // Outstanding operations; issue and response in one cycle cancel out.
    always_comb begin
        count_d = count_q;
        case ({issue, rsp_fire})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_a_q     <= '0;
            pipe_b_q     <= '0;
            pipe_p_q     <= '0;
            pipe_q_q     <= '0;
            pipe_m_q     <= 1'b0;
            pipe_valid_q <= 1'b0;
            last_q       <= 1'b1;
            tag_vld_q    <= '0;
            tag_id_q     <= '0;
            count_q      <= '0;
            rsp0_valid_q <= 1'b0;
            rsp0_exp_q   <= '0;
            rsp0_mant_q  <= '0;
            rsp1_valid_q <= 1'b0;
            rsp1_exp_q   <= '0;
            rsp1_mant_q  <= '0;
        end else begin
            pipe_a_q     <= pipe_a_d;
            pipe_b_q     <= pipe_b_d;
            pipe_p_q     <= pipe_p_d;
            pipe_q_q     <= pipe_q_d;
            pipe_m_q     <= pipe_m_d;
            pipe_valid_q <= pipe_valid_d;
            last_q       <= last_d;
            tag_vld_q    <= tag_vld_d;
            tag_id_q     <= tag_id_d;
            count_q      <= count_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp0_exp_q   <= rsp0_exp_d;
            rsp0_mant_q  <= rsp0_mant_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp1_exp_q   <= rsp1_exp_d;
            rsp1_mant_q  <= rsp1_mant_d;
        end
    end

    assign pipe_a     = pipe_a_q;
    assign pipe_b     = pipe_b_q;
    assign pipe_p     = pipe_p_q;
    assign pipe_q     = pipe_q_q;
    assign pipe_m     = pipe_m_q;
    assign pipe_valid = pipe_valid_q;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp0_exp   = rsp0_exp_q;
    assign rsp0_mant  = rsp0_mant_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp1_exp   = rsp1_exp_q;
    assign rsp1_mant  = rsp1_mant_q;
    assign busy       = (count_q != '0);

endmodule

// File: tb/tb_fpadd_scheduler.sv
// ---------------------------------------------------------------------------
// tb_fpadd_scheduler
//
// Directed-vector bench. A driver issues per-cycle stimulus with the
// hand-derived expected grant, checks ready and pipe_* and pushes the
// expected response (exp = p + 1, mant = a ^ b, arrival cycle) into a
// scoreboard queue. A monitor checks every cycle: pops and compares each
// rsp pulse, checks held response data on both ports and busy.
// The shared datapath is modelled as a 4-stage delay line.
// ---------------------------------------------------------------------------
module tb_fpadd_scheduler;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [22:0] req0_a, req0_b, req1_a, req1_b;
    logic [7:0]  req0_p, req0_q, req1_p, req1_q;
    logic        req0_m, req1_m;
    logic [22:0] pipe_a, pipe_b;
    logic [7:0]  pipe_p, pipe_q;
    logic        pipe_m, pipe_valid;
    logic [7:0]  pipe_exp;
    logic [22:0] pipe_mant;
    logic        rsp0_valid, rsp1_valid;
    logic [7:0]  rsp0_exp, rsp1_exp;
    logic [22:0] rsp0_mant, rsp1_mant;
    logic        busy;

    fpadd_scheduler #(.LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_p(req0_p), .req0_q(req0_q), .req0_m(req0_m),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_p(req1_p), .req1_q(req1_q), .req1_m(req1_m),
        .pipe_a(pipe_a), .pipe_b(pipe_b), .pipe_p(pipe_p), .pipe_q(pipe_q),
        .pipe_m(pipe_m), .pipe_valid(pipe_valid),
        .pipe_exp(pipe_exp), .pipe_mant(pipe_mant),
        .rsp0_valid(rsp0_valid), .rsp0_exp(rsp0_exp), .rsp0_mant(rsp0_mant),
        .rsp1_valid(rsp1_valid), .rsp1_exp(rsp1_exp), .rsp1_mant(rsp1_mant),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Datapath model: result valid LAT edges after pipe_* change.
    logic [7:0]  dm_exp [LAT];
    logic [22:0] dm_mant[LAT];
    always @(posedge clk) begin
        dm_exp[0]  <= pipe_p + 8'd1;
        dm_mant[0] <= pipe_a ^ pipe_b;
        for (int i = 1; i < LAT; i++) begin
            dm_exp[i]  <= dm_exp[i-1];
            dm_mant[i] <= dm_mant[i-1];
        end
    end
    assign pipe_exp  = dm_exp[LAT-1];
    assign pipe_mant = dm_mant[LAT-1];

    typedef struct {
        bit          port;
        logic [7:0]  exp;
        logic [22:0] mant;
        int          due;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    logic [7:0]  h_exp [2];
    logic [22:0] h_mant[2];
    bit          mon_rst;
    exp_t        e;
    bit          fired;

    initial begin
        h_exp[0] = '0; h_exp[1] = '0; h_mant[0] = '0; h_mant[1] = '0;
    end

    always @(posedge clk) begin
        cyc++;
        mon_rst = rst;
        #2;
        if (mon_rst) begin
            // Everything in flight is discarded by the reset edge.
            sb_q.delete();
            h_exp[0] = '0; h_exp[1] = '0; h_mant[0] = '0; h_mant[1] = '0;
        end
        if (rsp0_valid && rsp1_valid) begin
            checks++; errors++;
            $display("FAIL rsp_both actual=both ports pulsing required=one (cycle %0d)", cyc);
        end else if (rsp0_valid || rsp1_valid) begin
            fired = rsp1_valid;
            if (sb_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL rsp_unexpected actual=pulse on port %0d required=none (cycle %0d)", fired, cyc);
            end else begin
                e = sb_q.pop_front();
                chk("rsp_port", 32'(fired), 32'(e.port));
                chk("rsp_cycle", 32'(cyc), 32'(e.due));
                chk("rsp_exp", 32'(fired ? rsp1_exp : rsp0_exp), 32'(e.exp));
                chk("rsp_mant", 32'(fired ? rsp1_mant : rsp0_mant), 32'(e.mant));
                h_exp[e.port]  = e.exp;
                h_mant[e.port] = e.mant;
                $display("rsp port=%0d exp=%02h mant=%06h cycle=%0d", fired,
                         fired ? rsp1_exp : rsp0_exp, fired ? rsp1_mant : rsp0_mant, cyc);
            end
        end
        chk("rsp0_exp_held", 32'(rsp0_exp), 32'(h_exp[0]));
        chk("rsp0_mant_held", 32'(rsp0_mant), 32'(h_mant[0]));
        chk("rsp1_exp_held", 32'(rsp1_exp), 32'(h_exp[1]));
        chk("rsp1_mant_held", 32'(rsp1_mant), 32'(h_mant[1]));
        chk("busy", 32'(busy), 32'(sb_q.size() != 0));
    end

    // ---------------- driver ----------------
    logic [22:0] m_a, m_b;
    logic [7:0]  m_p, m_q;
    logic        m_m;

    // g: expected grant (0, 1) or -1 for no issue.
    task automatic step(input bit v0, input bit v1,
                        input logic [22:0] a0, input logic [22:0] b0, input logic [7:0] p0, input bit mo0,
                        input logic [22:0] a1, input logic [22:0] b1, input logic [7:0] p1, input bit mo1,
                        input int g);
        exp_t x;
        @(negedge clk);
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_p = p0; req0_q = p0 ^ 8'h5A; req0_m = mo0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_p = p1; req1_q = p1 ^ 8'hA5; req1_m = mo1;
        #1;
        chk("req0_ready", 32'(req0_ready), 32'(g == 0));
        chk("req1_ready", 32'(req1_ready), 32'(g == 1));
        @(posedge clk);
        #1;
        if (g == 0) begin
            m_a = a0; m_b = b0; m_p = p0; m_q = p0 ^ 8'h5A; m_m = mo0;
        end else if (g == 1) begin
            m_a = a1; m_b = b1; m_p = p1; m_q = p1 ^ 8'hA5; m_m = mo1;
        end
        chk("pipe_valid", 32'(pipe_valid), 32'(g >= 0));
        chk("pipe_a", 32'(pipe_a), 32'(m_a));
        chk("pipe_b", 32'(pipe_b), 32'(m_b));
        chk("pipe_p", 32'(pipe_p), 32'(m_p));
        chk("pipe_q", 32'(pipe_q), 32'(m_q));
        chk("pipe_m", 32'(pipe_m), 32'(m_m));
        if (g >= 0) begin
            x.port = (g == 1);
            x.exp  = m_p + 8'd1;
            x.mant = m_a ^ m_b;
            x.due  = cyc + LAT + 1;
            sb_q.push_back(x);
            $display("issue port=%0d a=%06h b=%06h p=%02h m=%0d cycle=%0d", g, m_a, m_b, m_p, m_m, cyc);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_req0_ready", 32'(req0_ready), 32'(0));
        chk("rst_req1_ready", 32'(req1_ready), 32'(0));
        chk("rst_pipe_valid", 32'(pipe_valid), 32'(0));
        chk("rst_pipe_a", 32'(pipe_a), 32'(0));
        chk("rst_pipe_b", 32'(pipe_b), 32'(0));
        chk("rst_pipe_p", 32'(pipe_p), 32'(0));
        chk("rst_pipe_q", 32'(pipe_q), 32'(0));
        chk("rst_pipe_m", 32'(pipe_m), 32'(0));
        chk("rst_rsp0_valid", 32'(rsp0_valid), 32'(0));
        chk("rst_rsp1_valid", 32'(rsp1_valid), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        m_a = '0; m_b = '0; m_p = '0; m_q = '0; m_m = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst = 1'b0;
        $display("reset released cycle=%0d", cyc);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=still running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_p = '0; req0_q = '0; req0_m = 1'b0;
        req1_a = '0; req1_b = '0; req1_p = '0; req1_q = '0; req1_m = 1'b0;
        m_a = '0; m_b = '0; m_p = '0; m_q = '0; m_m = 1'b0;
        repeat (2) @(posedge clk);
        do_reset();

        // Single req0 operation: exp 0x7F, mant 0x34C000, 5 edges later.
        step(1, 0, 23'h280000, 23'h1CC000, 8'h7E, 0, 0, 0, 0, 0, 0);
        idle(7);

        // req1-only grant, then a tie goes to req0; continuous tie alternates.
        step(0, 1, 0, 0, 0, 0, 23'h000111, 23'h000222, 8'h10, 1, 1);
        step(1, 1, 23'h100001, 23'h000F0F, 8'h20, 1, 23'h200002, 23'h0F0F00, 8'h30, 0, 0);
        step(1, 1, 23'h100003, 23'h000F0F, 8'h21, 0, 23'h200004, 23'h0F0F00, 8'h31, 1, 1);
        step(1, 1, 23'h100005, 23'h000F0F, 8'h22, 1, 23'h200006, 23'h0F0F00, 8'h32, 0, 0);
        step(1, 1, 23'h100007, 23'h000F0F, 8'h23, 0, 23'h200008, 23'h0F0F00, 8'h33, 1, 1);
        step(1, 1, 23'h100009, 23'h000F0F, 8'h24, 1, 23'h20000A, 23'h0F0F00, 8'h34, 0, 0);
        step(1, 1, 23'h10000B, 23'h000F0F, 8'h25, 0, 23'h20000C, 23'h0F0F00, 8'hFF, 1, 1);
        idle(7);

        // req1 back-to-back, p = 0x80, distinct a.
        step(0, 1, 0, 0, 0, 0, 23'h000001, 23'h7FFFFF, 8'h80, 1, 1);
        step(0, 1, 0, 0, 0, 0, 23'h000010, 23'h7FFFFF, 8'h80, 1, 1);
        step(0, 1, 0, 0, 0, 0, 23'h000100, 23'h7FFFFF, 8'h80, 0, 1);
        step(0, 1, 0, 0, 0, 0, 23'h001000, 23'h7FFFFF, 8'h80, 0, 1);
        idle(7);

        // Tie right after reset goes to req0; reset with 3 ops in flight.
        do_reset();
        step(1, 1, 23'h0ABCDE, 23'h012345, 8'h40, 1, 23'h055555, 23'h022222, 8'h50, 0, 0);
        step(1, 1, 23'h0ABCDE, 23'h012345, 8'h41, 1, 23'h055555, 23'h022222, 8'h51, 0, 1);
        step(1, 0, 23'h03C3C3, 23'h012345, 8'h42, 0, 0, 0, 0, 0, 0);
        idle(2);
        do_reset();
        idle(8);

        // One op, then 10 idle cycles: pipe_* held, no extra pulses.
        step(1, 0, 23'h7FFFFF, 23'h555555, 8'h01, 1, 0, 0, 0, 0, 0);
        idle(10);

        chk("sb_empty", 32'(sb_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
